// File: rtl/mac_frame_generator.sv
// -----------------------------------------------------------------------------
// mac_frame_generator
//
// Transmit-side Ethernet frame source on a 64-bit data / 8-bit control lane
// bus. Each requested frame goes out as START, preamble/SFD, header, a pattern
// payload with zero padding, the CRC-32 FCS and a terminate. After the
// terminate it sends IFG_WORDS all-idle words.
//
// Optional feature macro: MAC_GEN_FCS_ERR_INJECT_EN
//   When this macro is defined, the i_fcs_corrupt input is added. If it is set
//   with the request, bit 0 of the first FCS byte on the wire is inverted.
//   o_tx_fcs still reports the correct CRC.
//
// Ports
//   clk            clock
//   i_rst          synchronous active-high reset
//   i_start        frame request, sampled only in IDLE
//   i_payload_len  payload length N (0..1500), sampled with i_start
//   i_seed         first payload byte, sampled with i_start
//   i_fcs_corrupt  (optional) invert bit 0 of the first wire FCS byte
//   o_tx_data      lane 0 = bits [7:0] = first byte on the wire
//   o_tx_ctrl      bit k set: lane k carries a control character
//   o_tx_fcs       FCS of the current or most recent frame
//   o_fcs_valid    o_tx_fcs is valid
//   o_busy         a frame or IFG is in progress
//   o_len_error    one-cycle pulse when a request is rejected (N > 1500)
// -----------------------------------------------------------------------------
module mac_frame_generator #(
  parameter int          DATA_WIDTH    = 64,
  parameter int          CTRL_WIDTH    = 8,
  parameter int          FCS_WIDTH     = 32,
  parameter logic [7:0]  IDLE_CODE     = 8'h07,
  parameter logic [7:0]  START_CODE    = 8'hFB,
  parameter logic [7:0]  TERM_CODE     = 8'hFD,
  parameter logic [7:0]  PREAMBLE_CODE = 8'h55,
  parameter logic [7:0]  SFD_CODE      = 8'hD5,
  parameter logic [47:0] DST_ADDR_CODE = 48'h0180C2000001,
  parameter logic [47:0] SRC_ADDR_CODE = 48'h5A5152535455,
  parameter int          IFG_WORDS     = 2
) (
  input  logic                  clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [10:0]           i_payload_len,
  input  logic [7:0]            i_seed,
`ifdef MAC_GEN_FCS_ERR_INJECT_EN
  input  logic                  i_fcs_corrupt,
`endif
  output logic [DATA_WIDTH-1:0] o_tx_data,
  output logic [CTRL_WIDTH-1:0] o_tx_ctrl,
  output logic [FCS_WIDTH-1:0]  o_tx_fcs,
  output logic                  o_fcs_valid,
  output logic                  o_busy,
  output logic                  o_len_error
);

  localparam int LANES = CTRL_WIDTH;

  localparam logic [10:0] MAX_PAYLOAD = 11'd1500;
  localparam logic [11:0] MIN_PAYLOAD = 12'd46;

  localparam logic [DATA_WIDTH-1:0] IDLE_WORD  = {LANES{IDLE_CODE}};
  localparam logic [DATA_WIDTH-1:0] START_WORD = {{(LANES-1){IDLE_CODE}}, START_CODE};
  localparam logic [DATA_WIDTH-1:0] PRE_WORD   = {SFD_CODE, {(LANES-1){PREAMBLE_CODE}}};
  localparam logic [DATA_WIDTH-1:0] TERM_WORD  = {{(LANES-1){IDLE_CODE}}, TERM_CODE};

  // Both addresses as one 12-byte string; byte 0 (DA MSB) sits in the top bits.
  localparam logic [95:0] ADDR_BYTES = {DST_ADDR_CODE, SRC_ADDR_CODE};

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_PREAMBLE,
    S_DATA,
    S_TERM,
    S_IFG
  } state_t;

  state_t      state_q;
  logic [11:0] pos_q;        // frame byte index carried by lane 0 of the next DATA word
  logic [11:0] frame_len_q;  // F = 18 + max(N,46)
  logic [11:0] pay_end_q;    // first byte index after the payload (14 + N)
  logic [11:0] fcs_pos_q;    // index of the first FCS byte (F - 4)
  logic [10:0] len_q;
  logic [7:0]  seed_q;
  logic        corrupt_q;
  logic [31:0] crc_q;        // running (non-inverted) CRC register
  logic [7:0]  ifg_cnt_q;

  logic        corrupt_req;
  logic [11:0] pay_field;

`ifdef MAC_GEN_FCS_ERR_INJECT_EN
  assign corrupt_req = i_fcs_corrupt;
`else
  assign corrupt_req = 1'b0;
`endif

  assign pay_field = ({1'b0, i_payload_len} < MIN_PAYLOAD) ? MIN_PAYLOAD
                                                          : {1'b0, i_payload_len};

  // Reflected CRC-32 update for one byte, LSB first.
  function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'd0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  // Word assembly for the DATA state. Lanes are walked in wire order, so by the
  // time an FCS lane is reached every frame byte before it (including those
  // earlier in this same word) has already gone through crc_next.
  logic [DATA_WIDTH-1:0] data_word;
  logic [CTRL_WIDTH-1:0] ctrl_word;
  logic [31:0]           crc_next;
  logic [31:0]           fcs_val;
  logic                  fcs_first;
  logic [11:0]           lane_pos;
  logic [7:0]            lane_byte;
  logic [1:0]            fcs_idx;

  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    data_word = '0;
    ctrl_word = '0;
    crc_next  = crc_q;
    fcs_val   = ~crc_q;
    fcs_first = 1'b0;
    lane_pos  = '0;
    lane_byte = '0;
    fcs_idx   = '0;
    for (int k = 0; k < LANES; k++) begin
      lane_pos  = pos_q + 12'(k);
      lane_byte = 8'h00;
      if (lane_pos < 12'd12) begin
        lane_byte = ADDR_BYTES[8*(11 - int'(lane_pos)) +: 8];
      end else if (lane_pos == 12'd12) begin
        lane_byte = {5'd0, len_q[10:8]};
      end else if (lane_pos == 12'd13) begin
        lane_byte = len_q[7:0];
      end else if (lane_pos < pay_end_q) begin
        lane_byte = seed_q + 8'(lane_pos - 12'd14);
      end

      if (lane_pos < fcs_pos_q) begin
        crc_next = crc_byte(crc_next, lane_byte);
      end else if (lane_pos < frame_len_q) begin
        fcs_val   = ~crc_next;
        fcs_idx   = 2'(lane_pos - fcs_pos_q);
        lane_byte = fcs_val[{fcs_idx, 3'b000} +: 8];
        if (lane_pos == fcs_pos_q) begin
          fcs_first    = 1'b1;
          lane_byte[0] = lane_byte[0] ^ corrupt_q;
        end
      end else if (lane_pos == frame_len_q) begin
        lane_byte    = TERM_CODE;
        ctrl_word[k] = 1'b1;
      end else begin
        lane_byte    = IDLE_CODE;
        ctrl_word[k] = 1'b1;
      end
      data_word[8*k +: 8] = lane_byte;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated with non-blocking assignments only.
    if (i_rst) begin
      state_q     <= S_IDLE;
      o_tx_data   <= IDLE_WORD;
      o_tx_ctrl   <= '1;
      o_tx_fcs    <= '0;
      o_fcs_valid <= 1'b0;
      o_busy      <= 1'b0;
      o_len_error <= 1'b0;
      pos_q       <= '0;
      frame_len_q <= '0;
      pay_end_q   <= '0;
      fcs_pos_q   <= '0;
      len_q       <= '0;
      seed_q      <= '0;
      corrupt_q   <= 1'b0;
      crc_q       <= '1;
      ifg_cnt_q   <= '0;
    end else begin
      o_len_error <= 1'b0;
      case (state_q)
        S_IDLE: begin
          o_tx_data <= IDLE_WORD;
          o_tx_ctrl <= '1;
          o_busy    <= 1'b0;
          if (i_start) begin
            if (i_payload_len > MAX_PAYLOAD) begin
              o_len_error <= 1'b1;
            end else begin
              len_q       <= i_payload_len;
              seed_q      <= i_seed;
              corrupt_q   <= corrupt_req;
              pay_end_q   <= {1'b0, i_payload_len} + 12'd14;
              fcs_pos_q   <= pay_field + 12'd14;
              frame_len_q <= pay_field + 12'd18;
              state_q     <= S_START;
            end
          end
        end

        S_START: begin
          o_tx_data   <= START_WORD;
          o_tx_ctrl   <= '1;
          o_busy      <= 1'b1;
          o_fcs_valid <= 1'b0;
          state_q     <= S_PREAMBLE;
        end

        S_PREAMBLE: begin
          o_tx_data <= PRE_WORD;
          o_tx_ctrl <= '0;
          pos_q     <= '0;
          crc_q     <= '1;
          state_q   <= S_DATA;
        end

        S_DATA: begin
          o_tx_data <= data_word;
          o_tx_ctrl <= ctrl_word;
          crc_q     <= crc_next;
          pos_q     <= pos_q + 12'd8;
          if (fcs_first) begin
            o_tx_fcs    <= ~crc_next;
            o_fcs_valid <= 1'b1;
          end
          // The terminate fits in this word unless the frame ends exactly on
          // a word boundary, in which case a separate TERM word follows.
          if (frame_len_q <= pos_q + 12'd7) begin
            ifg_cnt_q <= '0;
            state_q   <= S_IFG;
          end else if (frame_len_q == pos_q + 12'd8) begin
            state_q <= S_TERM;
          end
        end

        S_TERM: begin
          o_tx_data <= TERM_WORD;
          o_tx_ctrl <= '1;
          ifg_cnt_q <= '0;
          state_q   <= S_IFG;
        end

        S_IFG: begin
          o_tx_data <= IDLE_WORD;
          o_tx_ctrl <= '1;
          o_busy    <= 1'b1;
          if (ifg_cnt_q == 8'(IFG_WORDS - 1)) begin
            state_q <= S_IDLE;
          end else begin
            ifg_cnt_q <= ifg_cnt_q + 8'd1;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mac_frame_generator.md
# mac_frame_generator

Transmit-side frame source for the 1.6T MII test path. It builds complete Ethernet frames on a 64-bit data / 8-bit control lane bus: start, preamble/SFD, header, pattern payload with padding, CRC-32 FCS and terminate. Frames are separated by idles. It sits directly upstream of the MAC checker and drives that stage's data, control and FCS inputs.

## Interface
- DATA_WIDTH, 64, data bus width; only 64 is supported.
- CTRL_WIDTH, 8, one control bit per byte lane.
- FCS_WIDTH, 32, FCS width.
- IDLE_CODE / START_CODE / TERM_CODE, 8'h07 / 8'hFB / 8'hFD, control characters.
- PREAMBLE_CODE / SFD_CODE, 8'h55 / 8'hD5.
- DST_ADDR_CODE, 48'h0180C2000001, destination address; MSB byte is sent first.
- SRC_ADDR_CODE, 48'h5A5152535455, source address; MSB byte is sent first.
- IFG_WORDS, 2, minimum number of all-idle words after each terminate.

Ports:
- clk  in  1  clock.
- i_rst  in  1  synchronous active-high reset.
- i_start  in  1  frame request; sampled only in IDLE.
- i_payload_len  in  11  payload bytes N, valid range 0..1500; sampled with i_start.
- i_seed  in  8  first payload byte; sampled with i_start.
- o_tx_data  out  64  lane 0 = bits [7:0] = first byte on the wire.
- o_tx_ctrl  out  8  bit k set means lane k carries a control character.
- o_tx_fcs  out  32  FCS of the current or most recent frame.
- o_fcs_valid  out  1  o_tx_fcs is valid.
- o_busy  out  1  a frame or IFG is in progress.
- o_len_error  out  1  one-cycle pulse when a request is rejected.

## Operation
- States: IDLE, START, PREAMBLE, DATA, TERM, IFG.
- IDLE:
  - Outputs all-idle: data 8x07, ctrl 8'hFF.
  - i_start=1 with N≤1500 latches N and seed, then goes to START.
  - i_start=1 with N>1500 pulses o_len_error and stays in IDLE.
- START: emits one word with lane 0 = FB and lanes 1-7 = 07; ctrl 8'hFF.
- PREAMBLE: emits one word with lanes 0-6 = 55 and lane 7 = D5; ctrl 8'h00.
- DATA:
  - Frame byte stream, packed lane 0 upward, 8 bytes per word, ctrl 0 on data lanes.
  - Order: DA (6 bytes), SA (6 bytes), length/type (2 bytes: N[15:8], then N[7:0]), payload, pad, FCS (4 bytes).
  - Payload byte k = (seed + k) mod 256.
  - Pad bytes are 0x00, added until the payload field is max(N,46) bytes.
  - Frame length F = 18 + max(N,46), range 64..1518.
- CRC-32:
  - Reflected polynomial 0xEDB88320, init 0xFFFFFFFF, final XOR 0xFFFFFFFF.
  - Covers DA through the last pad byte.
  - FCS is sent LSB byte first: o_tx_fcs[7:0] goes in the first FCS lane.
  - CRC advances up to 8 bytes per cycle.
  - FCS bytes may share a word with the last payload bytes, or straddle two words. In either case the FCS inserted is the final CRC.
- Terminate placement, with r = F mod 8:
  - r≠0: the last DATA word carries FD in lane r and 07 in lanes above r; ctrl bits [7:r] are set. TERM is skipped.
  - r=0: an extra TERM word follows with FD in lane 0 and 07 elsewhere; ctrl 8'hFF.
- IFG: IFG_WORDS all-idle words, then return to IDLE.
- o_busy is 1 in every state except IDLE.
- i_start is ignored while o_busy=1.
- o_tx_fcs / o_fcs_valid:
  - Updated in the cycle the first FCS byte is driven, and held.
  - o_fcs_valid drops in the START word of the next frame.

## Timing
- All outputs are registered.
- Reset values: o_tx_data = 64'h0707070707070707, o_tx_ctrl = 8'hFF, o_tx_fcs = 0, o_fcs_valid = 0, o_busy = 0, o_len_error = 0.
- i_start at edge t → START word on the outputs after edge t+1; o_busy=1 from that same edge.
- Word count from START through terminate: 2 + ceil(F/8) + (r==0 ? 1 : 0).
- Back-to-back requests: the earliest next START comes after IFG_WORDS idles, then one IDLE cycle.
- Reset mid-frame: all-idle on the next edge with no terminate emitted; latched request discarded; o_fcs_valid = 0.
- i_start coincident with i_rst: reset wins.

## Configuration
- MAC_GEN_FCS_ERR_INJECT_EN defined:
  - Adds input port i_fcs_corrupt, sampled with i_start.
  - When it was 1, bit 0 of the first transmitted FCS byte is inverted on the wire.
  - o_tx_fcs still carries the correct CRC.
- Macro undefined: the port is absent and the FCS on the wire is always correct.

## Test plan
- Reset, then no requests → outputs are the reset values; idle words with ctrl 8'hFF.
- N=46, seed 8'h00 →
  - START word, then 55x7 + D5.
  - 8 DATA words; word 0 lanes 0-5 = 01 80 C2 00 00 01.
  - Length bytes 00 2E in lanes 4-5 of word 1.
  - Then a TERM word with FD in lane 0, ctrl 8'hFF.
  - 11 words total, then 2 idle words.
- N=50, seed 8'h10 →
  - Payload bytes 10..41.
  - Last DATA word: lanes 0-3 = FCS, lane 4 = FD, ctrl 8'hF0.
- N=5 →
  - Length bytes 00 05; 41 zero pad bytes; F=64.
  - FCS equals the bench CRC model, which is itself checked against CRC("123456789") = 0xCBF43926.
- Boundary and reject cases:
  - N=1500 → F=1518, r=6, FD in lane 6.
  - N=1501 → o_len_error pulses for 1 cycle; output stays idle.
- Reset asserted in the 4th DATA word → idle on the next edge.
  - A new i_start afterwards produces a normal frame.
  - With MAC_GEN_FCS_ERR_INJECT_EN defined and i_fcs_corrupt=1, wire FCS byte 0 = o_tx_fcs[7:0] ^ 8'h01.
